// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 round controller and its K/f lookup.
package sha1_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned RND_W  = 8;
  localparam int unsigned T_W    = 7;
  localparam int unsigned PH_W   = 2;

  // Round bounds: last loaded word, last expanded word, last flush round.
  localparam logic [RND_W-1:0] RND_FIRST     = 8'd1;
  localparam logic [RND_W-1:0] RND_LOAD_END  = 8'd16;
  localparam logic [RND_W-1:0] RND_EXP_END   = 8'd80;
  localparam logic [RND_W-1:0] RND_FINAL_END = 8'd83;

  localparam logic [T_W-1:0] T_STAGE1 = 7'd20;
  localparam logic [T_W-1:0] T_STAGE2 = 7'd40;
  localparam logic [T_W-1:0] T_STAGE3 = 7'd60;

  localparam logic [WORD_W-1:0] K_00_19 = 32'h5A82_7999;
  localparam logic [WORD_W-1:0] K_20_39 = 32'h6ED9_EBA1;
  localparam logic [WORD_W-1:0] K_40_59 = 32'h8F1B_BCDC;
  localparam logic [WORD_W-1:0] K_60_79 = 32'hCA62_C1D6;

  typedef enum logic [1:0] {
    F_CH     = 2'd0,
    F_PARITY = 2'd1,
    F_MAJ    = 2'd2
  } f_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_EXPAND = 3'd2,
    ST_FINAL  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] k;
    f_sel_e            f;
  } kf_t;

  // External phase code; FINAL and DONE share one code.
  function automatic logic [PH_W-1:0] phase_of(input state_e s);
    logic [PH_W-1:0] ph;
    ph = 2'b00;
    case (s)
      ST_LOAD:            ph = 2'b01;
      ST_EXPAND:          ph = 2'b10;
      ST_FINAL, ST_DONE:  ph = 2'b11;
      default:            ph = 2'b00;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/sha1_kf_lut.sv
// Combinational map from round index t to the SHA-1 constant K_t and f selector.
module sha1_kf_lut
  import sha1_pkg::*;
(
  input  logic [T_W-1:0] t_i,
  output kf_t            kf_o
);

  always_comb begin
    kf_o.k = K_00_19;
    kf_o.f = F_CH;
    if (t_i < T_STAGE1) begin
      kf_o.k = K_00_19;
      kf_o.f = F_CH;
    end else if (t_i < T_STAGE2) begin
      kf_o.k = K_20_39;
      kf_o.f = F_PARITY;
    end else if (t_i < T_STAGE3) begin
      kf_o.k = K_40_59;
      kf_o.f = F_MAJ;
    end else begin
      kf_o.k = K_60_79;
      kf_o.f = F_PARITY;
    end
  end

endmodule

// File: rtl/sha1_round_ctrl.sv
// SHA-1 block sequencer: loads 16 words, free-runs 64 expansion and 3 flush rounds,
// and tags each produced W_t with t, K_t and the round function select.
module sha1_round_ctrl
  import sha1_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_last,
  output logic              word_ready,
  output logic              sched_enable,
  output logic [RND_W-1:0]  sched_round,
  output logic [WORD_W-1:0] sched_data,
  output logic [PH_W-1:0]   sched_state,
  output logic              round_valid,
  output logic [T_W-1:0]    t_index,
  output logic [WORD_W-1:0] k_const,
  output logic [1:0]        f_sel,
  output logic              first_block,
  output logic              busy,
  output logic              block_done,
  output logic              msg_done
);

  state_e            state_q;
  logic [RND_W-1:0]  rnd_q;
  logic              last_blk_q;
  logic              first_block_q;
  logic              round_valid_q;
  logic [T_W-1:0]    t_index_q;
  logic [WORD_W-1:0] k_q;
  logic [1:0]        f_q;
  logic              block_done_q;
  logic              msg_done_q;

  logic              in_load;
  logic              in_run;
  logic              enable_c;
  logic              rv_d;
  logic [T_W-1:0]    t_cur;
  logic [T_W-1:0]    t_d;
  logic [WORD_W-1:0] k_d;
  logic [1:0]        f_d;
  logic [RND_W-1:0]  rnd_inc;
  kf_t               kf;

  assign in_load  = (state_q == ST_LOAD);
  assign in_run   = (state_q == ST_EXPAND) || (state_q == ST_FINAL);
  assign enable_c = (in_load && word_valid) || in_run;
  assign rnd_inc  = RND_W'(rnd_q + 8'd1);
  assign t_cur    = T_W'(rnd_q - 8'd1);

  sha1_kf_lut u_kf_lut (
    .t_i  (t_cur),
    .kf_o (kf)
  );

  // Rounds 1..80 produce W_0..W_79 one cycle later; the flush rounds produce nothing.
  assign rv_d = enable_c && (rnd_q >= RND_FIRST) && (rnd_q <= RND_EXP_END);
  assign t_d  = rv_d ? t_cur : '0;
  assign k_d  = rv_d ? kf.k : '0;
  assign f_d  = rv_d ? 2'(kf.f) : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      rnd_q         <= '0;
      last_blk_q    <= 1'b0;
      first_block_q <= 1'b0;
      round_valid_q <= 1'b0;
      t_index_q     <= '0;
      k_q           <= '0;
      f_q           <= '0;
      block_done_q  <= 1'b0;
      msg_done_q    <= 1'b0;
    end else begin
      round_valid_q <= rv_d;
      t_index_q     <= t_d;
      k_q           <= k_d;
      f_q           <= f_d;
      block_done_q  <= 1'b0;
      msg_done_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q       <= ST_LOAD;
            rnd_q         <= RND_FIRST;
            first_block_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (word_valid) begin
            if (rnd_q == RND_FIRST) begin
              last_blk_q <= word_last;
            end
            rnd_q <= rnd_inc;
            if (rnd_q == RND_LOAD_END) begin
              state_q <= ST_EXPAND;
            end
          end
        end
        ST_EXPAND: begin
          rnd_q <= rnd_inc;
          if (rnd_q == RND_EXP_END) begin
            state_q <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          // rnd parks at the last flush round; the done pulses land in DONE.
          if (rnd_q == RND_FINAL_END) begin
            state_q      <= ST_DONE;
            block_done_q <= 1'b1;
            msg_done_q   <= last_blk_q;
          end else begin
            rnd_q <= rnd_inc;
          end
        end
        ST_DONE: begin
          first_block_q <= 1'b0;
          if (last_blk_q) begin
            state_q    <= ST_IDLE;
            rnd_q      <= '0;
            last_blk_q <= 1'b0;
          end else begin
            state_q <= ST_LOAD;
            rnd_q   <= RND_FIRST;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rnd_q   <= '0;
        end
      endcase
    end
  end

  // Load-side handshake is zero-latency so the datapath sees word_data in its round.
  assign word_ready   = in_load;
  assign sched_enable = enable_c;
  assign sched_round  = (in_load || in_run) ? rnd_q : '0;
  assign sched_data   = in_load ? word_data : '0;
  assign sched_state  = phase_of(state_q);
  assign busy         = (state_q != ST_IDLE);

  assign round_valid  = round_valid_q;
  assign t_index      = t_index_q;
  assign k_const      = k_q;
  assign f_sel        = f_q;
  assign first_block  = first_block_q;
  assign block_done   = block_done_q;
  assign msg_done     = msg_done_q;

endmodule

// File: tb/tb_sha1_round_ctrl.sv
// Bench for sha1_round_ctrl: round-level reference model checked every cycle,
// plus literal expectations for counts, K/f boundaries and the "abc" schedule.
module tb_sha1_round_ctrl;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_last;
  logic        word_ready;
  logic        sched_enable;
  logic [7:0]  sched_round;
  logic [31:0] sched_data;
  logic [1:0]  sched_state;
  logic        round_valid;
  logic [6:0]  t_index;
  logic [31:0] k_const;
  logic [1:0]  f_sel;
  logic        first_block;
  logic        busy;
  logic        block_done;
  logic        msg_done;

  int errors = 0;
  int checks = 0;

  sha1_round_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_last    (word_last),
    .word_ready   (word_ready),
    .sched_enable (sched_enable),
    .sched_round  (sched_round),
    .sched_data   (sched_data),
    .sched_state  (sched_state),
    .round_valid  (round_valid),
    .t_index      (t_index),
    .k_const      (k_const),
    .f_sel        (f_sel),
    .first_block  (first_block),
    .busy         (busy),
    .block_done   (block_done),
    .msg_done     (msg_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a message is a sequence of blocks, each being rounds 1..83 then one done cycle (84).
  logic [31:0] K_TAB [4] = '{32'h5A827999, 32'h6ED9EBA1, 32'h8F1BBCDC, 32'hCA62C1D6};
  logic [1:0]  F_TAB [4] = '{2'd0, 2'd1, 2'd2, 2'd1};

  bit          m_active, m_last, m_first, m_rv, m_bd, m_md;
  int          m_r, m_t;
  logic [31:0] m_k;
  logic [1:0]  m_f;

  function automatic bit model_en();
    return m_active && (((m_r >= 1) && (m_r <= 16) && word_valid) || ((m_r >= 17) && (m_r <= 83)));
  endfunction

  always @(posedge clk) begin : model_p
    bit en_v;
    bit rv_v;
    int t_v;
    en_v = model_en();
    rv_v = en_v && (m_r <= 80);
    t_v  = rv_v ? m_r - 1 : 0;
    if (!reset_n) begin
      m_active <= 1'b0; m_last <= 1'b0; m_first <= 1'b0;
      m_rv <= 1'b0; m_bd <= 1'b0; m_md <= 1'b0;
      m_r <= 0; m_t <= 0; m_k <= '0; m_f <= '0;
    end else begin
      m_rv <= rv_v;
      m_t  <= t_v;
      m_k  <= rv_v ? K_TAB[t_v / 20] : 32'h0;
      m_f  <= rv_v ? F_TAB[t_v / 20] : 2'd0;
      m_bd <= m_active && (m_r == 83);
      m_md <= m_active && (m_r == 83) && m_last;
      if (!m_active) begin
        if (start) begin
          m_active <= 1'b1; m_r <= 1; m_first <= 1'b1;
        end
      end else if (m_r == 84) begin
        m_first <= 1'b0;
        if (m_last) begin
          m_active <= 1'b0; m_r <= 0;
        end else begin
          m_r <= 1;
        end
      end else if (en_v) begin
        if (m_r == 1) m_last <= word_last;
        m_r <= m_r + 1;
      end
    end
  end

  // Downstream schedule datapath fed from the controller, plus event counters.
  logic [31:0] w [80];
  int se_cnt = 0, bd_cnt = 0, md_cnt = 0, both_cnt = 0, fb_cnt = 0, stall8_cnt = 0, kf_hits = 0;

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  always @(negedge clk) begin : compare_p
    logic [1:0] ph;
    int t;
    ph = !m_active ? 2'd0 : (m_r <= 16) ? 2'd1 : (m_r <= 80) ? 2'd2 : 2'd3;
    chk("busy",         32'(busy),         32'(m_active));
    chk("word_ready",   32'(word_ready),   32'(m_active && (m_r <= 16)));
    chk("sched_enable", 32'(sched_enable), 32'(model_en()));
    chk("sched_round",  32'(sched_round),  (m_active && (m_r <= 83)) ? 32'(m_r) : 32'h0);
    chk("sched_data",   sched_data,        (m_active && (m_r <= 16)) ? word_data : 32'h0);
    chk("sched_state",  32'(sched_state),  32'(ph));
    chk("round_valid",  32'(round_valid),  32'(m_rv));
    chk("t_index",      32'(t_index),      32'(m_t));
    chk("k_const",      k_const,           m_k);
    chk("f_sel",        32'(f_sel),        32'(m_f));
    chk("first_block",  32'(first_block),  32'(m_first));
    chk("block_done",   32'(block_done),   32'(m_bd));
    chk("msg_done",     32'(msg_done),     32'(m_md));

    if (round_valid) begin
      case (t_index)
        7'd19: begin kf_hits++; chk("kf19_k", k_const, 32'h5A827999); chk("kf19_f", 32'(f_sel), 32'd0); end
        7'd20: begin kf_hits++; chk("kf20_k", k_const, 32'h6ED9EBA1); chk("kf20_f", 32'(f_sel), 32'd1); end
        7'd39: begin kf_hits++; chk("kf39_k", k_const, 32'h6ED9EBA1); chk("kf39_f", 32'(f_sel), 32'd1); end
        7'd40: begin kf_hits++; chk("kf40_k", k_const, 32'h8F1BBCDC); chk("kf40_f", 32'(f_sel), 32'd2); end
        7'd59: begin kf_hits++; chk("kf59_k", k_const, 32'h8F1BBCDC); chk("kf59_f", 32'(f_sel), 32'd2); end
        7'd60: begin kf_hits++; chk("kf60_k", k_const, 32'hCA62C1D6); chk("kf60_f", 32'(f_sel), 32'd1); end
        7'd79: begin kf_hits++; chk("kf79_k", k_const, 32'hCA62C1D6); chk("kf79_f", 32'(f_sel), 32'd1); end
        default: ;
      endcase
    end

    se_cnt     += 32'(sched_enable);
    bd_cnt     += 32'(block_done);
    md_cnt     += 32'(msg_done);
    both_cnt   += 32'(block_done && msg_done);
    fb_cnt     += 32'(first_block);
    stall8_cnt += 32'((sched_state == 2'd1) && !sched_enable && (sched_round == 8'd8));

    if (sched_enable && (sched_round >= 8'd1) && (sched_round <= 8'd80)) begin
      t = int'(sched_round) - 1;
      if (t < 16) w[t] <= sched_data;
      else        w[t] <= rotl1(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16]);
    end
  end

  // Block 0 carries the padded "abc" message; later blocks carry a simple pattern.
  function automatic logic [31:0] blk_word(input int blk, input int idx);
    if (blk == 0) begin
      if (idx == 0)  return 32'h61626380;
      if (idx == 15) return 32'h00000018;
      return 32'h0;
    end
    return 32'h01010000 + 32'(idx);
  endfunction

  // Runs one message; returns cycles from the start edge to the first IDLE cycle.
  task automatic run_msg(input int nblk, input int stall, input int rst_at,
                         input int start_at, output int cyc);
    int blk;
    int widx;
    int stall_left;
    blk = 0; widx = 0; stall_left = stall; cyc = 0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc = 1;
    while (busy && (cyc < 600)) begin
      word_valid = 1'b0; word_last = 1'b0; word_data = 32'h0; start = 1'b0;
      if (rst_at > 0 && sched_round == 8'(rst_at)) begin
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        return;
      end
      if (word_ready) begin
        if (widx == 7 && stall_left > 0) begin
          stall_left--;
        end else begin
          word_valid = 1'b1;
          word_data  = blk_word(blk, widx);
          word_last  = (widx == 0) && (blk == nblk - 1);
        end
      end
      if (start_at > 0 && sched_round == 8'(start_at)) start = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (word_valid) begin
        widx++;
        if (widx == 16) begin
          widx = 0;
          blk++;
        end
      end
    end
    word_valid = 1'b0; word_last = 1'b0; word_data = 32'h0; start = 1'b0;
    chk("run_timeout", 32'(busy), 32'h0);
  endtask

  task automatic chk_abc_sched(input string tag);
    chk({tag, "_w0"},  w[0],  32'h61626380);
    chk({tag, "_w15"}, w[15], 32'h00000018);
    chk({tag, "_w16"}, w[16], 32'hC2C4C700);
    chk({tag, "_w18"}, w[18], 32'h00000030);
    chk({tag, "_w19"}, w[19], 32'h85898E01);
  endtask

  initial begin : stim
    int cyc;
    int se0, bd0, md0, both0, fb0, st0, kf0;
    reset_n = 1'b0; start = 1'b0; word_valid = 1'b0; word_last = 1'b0; word_data = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_busy",  32'(busy),         32'h0);
    chk("rst_state", 32'(sched_state),  32'h0);
    chk("rst_ready", 32'(word_ready),   32'h0);
    chk("rst_en",    32'(sched_enable), 32'h0);

    // Single block, word_valid held high.
    se0 = se_cnt; bd0 = bd_cnt; md0 = md_cnt; both0 = both_cnt; kf0 = kf_hits;
    run_msg(1, 0, 0, 0, cyc);
    chk("t1_cycles", 32'(cyc), 32'd85);
    chk("t1_enable_cycles", 32'(se_cnt - se0), 32'd83);
    chk("t1_block_done", 32'(bd_cnt - bd0), 32'd1);
    chk("t1_msg_done", 32'(md_cnt - md0), 32'd1);
    chk("t1_done_same_cycle", 32'(both_cnt - both0), 32'd1);
    chk("t1_kf_hits", 32'(kf_hits - kf0), 32'd7);
    chk_abc_sched("t1");

    // Stall of five cycles after word 7.
    st0 = stall8_cnt; bd0 = bd_cnt;
    run_msg(1, 5, 0, 0, cyc);
    chk("t2_cycles", 32'(cyc), 32'd90);
    chk("t2_stall_at_8", 32'(stall8_cnt - st0), 32'd5);
    chk("t2_block_done", 32'(bd_cnt - bd0), 32'd1);
    chk_abc_sched("t2");

    // Two-block message.
    bd0 = bd_cnt; md0 = md_cnt; fb0 = fb_cnt;
    run_msg(2, 0, 0, 0, cyc);
    chk("t3_cycles", 32'(cyc), 32'd169);
    chk("t3_block_done", 32'(bd_cnt - bd0), 32'd2);
    chk("t3_msg_done", 32'(md_cnt - md0), 32'd1);
    chk("t3_first_block_cycles", 32'(fb_cnt - fb0), 32'd84);

    // Reset mid-block at round 40, then a clean block.
    bd0 = bd_cnt; md0 = md_cnt;
    run_msg(1, 0, 40, 0, cyc);
    chk("t4_busy",   32'(busy),        32'h0);
    chk("t4_state",  32'(sched_state), 32'h0);
    chk("t4_round",  32'(sched_round), 32'h0);
    chk("t4_rv",     32'(round_valid), 32'h0);
    chk("t4_k",      k_const,          32'h0);
    chk("t4_first",  32'(first_block), 32'h0);
    @(negedge clk);
    chk("t4_no_block_done", 32'(bd_cnt - bd0), 32'd0);
    chk("t4_no_msg_done",   32'(md_cnt - md0), 32'd0);
    run_msg(1, 0, 0, 0, cyc);
    chk("t4_clean_cycles", 32'(cyc), 32'd85);
    chk("t4_clean_done", 32'(bd_cnt - bd0), 32'd1);

    // start pulsed mid-block has no effect.
    bd0 = bd_cnt; md0 = md_cnt;
    run_msg(1, 0, 0, 50, cyc);
    chk("t5_cycles", 32'(cyc), 32'd85);
    chk("t5_block_done", 32'(bd_cnt - bd0), 32'd1);
    chk("t5_msg_done", 32'(md_cnt - md0), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
